uart_tx_framer: RTL and testbench

- Serialises parallel bytes into an asynchronous UART frame: start bit, data bits LSB first, optional parity, stop bit(s).
- Sits directly upstream of the IrDA modulator stage and drives its uart_tx_data input.
- Line idles high, so the modulator emits no pulses when idle; each low bit is one full bit period.
- A one-entry holding register lets back-to-back bytes go out with no idle gap between frames.

---
 rtl/uart_tx_framer.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_framer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises parallel bytes into asynchronous UART frames
// (start bit, DATA_BITS data bits LSB first, optional even parity, stop bits).
// Drives the IrDA modulator's uart_tx_data input, so the line idles high.
// A one-entry holding register allows back-to-back frames with no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx_data,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PEN  = BW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [BW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  logic accept;
  logic baud_end;
  logic stop_end;
  logic load;

  assign accept   = tx_valid & tx_ready;
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign stop_end = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);
  // The shifter takes the held byte when idle, or straight after the last stop bit.
  assign load     = hold_full && ((state == IDLE) || stop_end);
  assign tx_busy  = (state != IDLE);

  // Holding register: an accept wins over a same-cycle load so the new byte stays queued.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
    end else if (accept) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
      tx_ready  <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
    end
  end

  // Frame sequencer: the line register is set to the value of the bit being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shifter      <= '0;
      uart_tx_data <= 1'b1;
      tx_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      tx_done <= (state == STOP) && (baud_cnt == BAUD_PEN) && (bit_cnt == STOP_LAST);
      if (load) begin
        shifter      <= hold_data;
`ifdef UART_TX_PARITY_EN
        parity_bit   <= ^hold_data;
`endif
        state        <= START;
        baud_cnt     <= '0;
        bit_cnt      <= '0;
        uart_tx_data <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            uart_tx_data <= 1'b1;
          end
          START: begin
            if (baud_end) begin
              baud_cnt     <= '0;
              bit_cnt      <= '0;
              state        <= DATA;
              uart_tx_data <= shifter[0];
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          DATA: begin
            if (baud_end) begin
              baud_cnt <= '0;
              shifter  <= {1'b0, shifter[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt      <= '0;
`ifdef UART_TX_PARITY_EN
                state        <= PARITY;
                uart_tx_data <= parity_bit;
`else
                state        <= STOP;
                uart_tx_data <= 1'b1;
`endif
              end else begin
                bit_cnt      <= bit_cnt + 3'd1;
                uart_tx_data <= shifter[1];
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (baud_end) begin
              baud_cnt     <= '0;
              bit_cnt      <= '0;
              state        <= STOP;
              uart_tx_data <= 1'b1;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (baud_end) begin
              baud_cnt <= '0;
              if (bit_cnt == STOP_LAST) begin
                bit_cnt      <= '0;
                state        <= IDLE;
                uart_tx_data <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            uart_tx_data <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed testbench for uart_tx_framer with CLKS_PER_BIT=16.
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity frames.
module tb_uart_tx_framer;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx_data;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx_framer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .STOP_BITS(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx_data(uart_tx_data),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  // 10 ns system clock
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected line level for frame bit index idx of byte d
  function automatic logic expBit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_line"}, 32'(uart_tx_data), 32'd1);
    checkOutput({tag, "_ready"}, 32'(tx_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(tx_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(tx_done), 32'd0);
  endtask

  // Offer one byte for one cycle while the holding register is empty
  task automatic applyStimulus(input logic [7:0] d);
    checkOutput($sformatf("ready_before_%02h", d), 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick;
    tx_valid = 1'b0;
  endtask

  // Follow a frame cycle by cycle; optionally queue a byte, push a refused byte, or stop early
  task automatic checkFrame(input logic [7:0] d, input int offer_at, input logic [7:0] offer_d,
                            input int bp_at, input int abort_at);
    for (int j = 1; j <= FRAME; j++) begin
      tick;
      if (j == offer_at + 1 || j == bp_at + 1) tx_valid = 1'b0;
      checkOutput($sformatf("line_%02h_c%0d", d, j), 32'(uart_tx_data), 32'(expBit(d, (j - 1) / CPB)));
      checkOutput($sformatf("busy_%02h_c%0d", d, j), 32'(tx_busy), 32'd1);
      checkOutput($sformatf("done_%02h_c%0d", d, j), 32'(tx_done), 32'(j == FRAME));
      if (j == offer_at + 1 || j == bp_at + 1)
        checkOutput($sformatf("ready_full_%02h_c%0d", d, j), 32'(tx_ready), 32'd0);
      if (j == offer_at) begin
        tx_data  = offer_d;
        tx_valid = 1'b1;
      end
      if (j == bp_at) begin
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
      end
      if (j == abort_at) return;
    end
  endtask

  initial begin
    // Reset held for three cycles, then one cycle after release
    for (int i = 0; i < 3; i++) begin
      tick;
      checkIdle($sformatf("reset_%0d", i));
    end
    reset = 1'b0;
    tick;
    checkIdle("post_reset");

    // Single byte 0xA5
    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5);
    checkFrame(8'hA5, -1, 8'h00, -1, -1);
    tick;
    checkIdle("after_a5");

    // Back-to-back 0x00 then 0xFF, with a refused 0x3C while the hold is full
    $display("[TB] back-to-back 0x00/0xFF with backpressure");
    applyStimulus(8'h00);
    checkFrame(8'h00, 20, 8'hFF, 40, -1);
    checkFrame(8'hFF, -1, 8'h00, -1, -1);
    for (int i = 0; i < 2 * CPB; i++) begin
      tick;
      checkIdle($sformatf("after_ff_%0d", i));
    end

    // Reset during data bit 3 of 0x55, then a clean 0x81 frame
    $display("[TB] reset mid-frame");
    applyStimulus(8'h55);
    checkFrame(8'h55, -1, 8'h00, -1, 70);
    reset = 1'b1;
    tick;
    checkIdle("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      tick;
      checkIdle($sformatf("after_abort_%0d", i));
    end
    applyStimulus(8'h81);
    checkFrame(8'h81, -1, 8'h00, -1, -1);
    tick;
    checkIdle("after_81");

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0)
    $display("[TB] parity frames");
    applyStimulus(8'h07);
    checkFrame(8'h07, -1, 8'h00, -1, -1);
    tick;
    checkIdle("after_07");
    applyStimulus(8'h03);
    checkFrame(8'h03, -1, 8'h00, -1, -1);
    tick;
    checkIdle("after_03");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
